// File: rtl/frontend_ctrl_if.sv
// Redirect handshake between the back-end (master) and the front-end sequencing
// controller (slave). The controller holds off new requests with redirect_ready.
interface frontend_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                redirect_valid;
  logic [1:0]          redirect_kind;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_kind,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_kind,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/frontend_ctrl.sv
// Qu front-end sequencing controller: startup hold, redirect pulse plus timed
// flush window for the inter-stage FIFOs, external halt, and per-stage stalls.
module frontend_ctrl #(
  parameter int PC_WIDTH       = 32,
  parameter int FLUSH_CYCLES   = 3,
  parameter int STARTUP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  frontend_ctrl_if.slave      redir,
  input  logic                halt_req,
  input  logic                map_full,
  input  logic                rob_full,
  input  logic                res_st_full,
  output logic                if_en,
  output logic                id_en,
  output logic                branch,
  output logic                jump,
  output logic                exception,
  output logic [PC_WIDTH-1:0] pc_override,
  output logic                stall,
  output logic                flush,
  output logic                if_stall,
  output logic                id_stall,
  output logic                mp_stall,
  output logic                rn_stall,
  output logic                busy,
  output logic [15:0]         redirect_cnt
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_RUN,
    ST_REDIRECT,
    ST_FLUSH,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    KIND_BRANCH    = 2'b00,
    KIND_JUMP      = 2'b01,
    KIND_EXCEPTION = 2'b10,
    KIND_RESERVED  = 2'b11
  } kind_t;

  // The counter reloads with N-1 so that a phase lasts exactly N cycles.
  localparam logic [3:0] STARTUP_LOAD = 4'(STARTUP_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  kind_t      kind;
  logic       ready;
  logic       accept;
  logic       not_run;

  assign kind   = kind_t'(redir.redirect_kind);
  assign ready  = (state == ST_RUN) || (state == ST_FLUSH) || (state == ST_HALT);
  assign accept = redir.redirect_valid && ready;

  assign redir.redirect_ready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_STARTUP;
      cnt          <= STARTUP_LOAD;
      redirect_cnt <= '0;
      pc_override  <= '0;
      branch       <= 1'b0;
      jump         <= 1'b0;
      exception    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values,
      // so the default clears below are safely overridden later in the block.
      branch    <= 1'b0;
      jump      <= 1'b0;
      exception <= 1'b0;

      if (accept) begin
        // Redirect wins over halt and counter expiry in every state.
        state        <= ST_REDIRECT;
        pc_override  <= redir.redirect_pc;
        redirect_cnt <= redirect_cnt + 16'd1;
        unique case (kind)
          KIND_BRANCH: branch    <= 1'b1;
          KIND_JUMP:   jump      <= 1'b1;
          default:     exception <= 1'b1;
        endcase
      end else begin
        unique case (state)
          ST_STARTUP: begin
            if (cnt == 4'd0) begin
              state <= halt_req ? ST_HALT : ST_RUN;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_RUN: begin
            if (halt_req) state <= ST_HALT;
          end
          ST_REDIRECT: begin
            state <= ST_FLUSH;
            cnt   <= FLUSH_LOAD;
          end
          ST_FLUSH: begin
            // halt_req is only consulted once the window has fully drained.
            if (cnt == 4'd0) begin
              state <= halt_req ? ST_HALT : ST_RUN;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_HALT: begin
            if (!halt_req) state <= ST_RUN;
          end
          // NOTE: unused encodings fall back to a clean restart rather than
          // leaving the controller stuck with every stage stalled forever.
          default: begin
            state <= ST_STARTUP;
            cnt   <= STARTUP_LOAD;
          end
        endcase
      end
    end
  end

  assign not_run  = (state != ST_RUN);
  assign if_en    = !not_run;
  assign id_en    = !not_run;
  assign stall    = not_run;
  assign busy     = not_run;
  assign if_stall = not_run;
  assign id_stall = not_run;
  assign flush    = (state == ST_REDIRECT) || (state == ST_FLUSH);

  // Back-pressure only gates the downstream stalls; it never moves the FSM.
  assign mp_stall = not_run || map_full;
  assign rn_stall = not_run || rob_full || res_st_full;

endmodule

// File: tb/tb_frontend_ctrl.sv
// Self-checking bench for frontend_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a cycle-count reference model.
module tb_frontend_ctrl;
  localparam int PC_WIDTH       = 32;
  localparam int FLUSH_CYCLES   = 3;
  localparam int STARTUP_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt_req = 1'b0;
  logic map_full = 1'b0;
  logic rob_full = 1'b0;
  logic res_st_full = 1'b0;
  logic if_en, id_en, branch, jump, exception, stall, flush;
  logic if_stall, id_stall, mp_stall, rn_stall, busy;
  logic [PC_WIDTH-1:0] pc_override;
  logic [15:0] redirect_cnt;

  frontend_ctrl_if #(.PC_WIDTH(PC_WIDTH)) redir ();

  frontend_ctrl #(
    .PC_WIDTH      (PC_WIDTH),
    .FLUSH_CYCLES  (FLUSH_CYCLES),
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redir       (redir),
    .halt_req    (halt_req),
    .map_full    (map_full),
    .rob_full    (rob_full),
    .res_st_full (res_st_full),
    .if_en       (if_en),
    .id_en       (id_en),
    .branch      (branch),
    .jump        (jump),
    .exception   (exception),
    .pc_override (pc_override),
    .stall       (stall),
    .flush       (flush),
    .if_stall    (if_stall),
    .id_stall    (id_stall),
    .mp_stall    (mp_stall),
    .rn_stall    (rn_stall),
    .busy        (busy),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  logic [12:0] dut_ctrl;
  assign dut_ctrl = {if_en, id_en, stall, flush, if_stall, id_stall, mp_stall,
                     rn_stall, busy, redir.redirect_ready, branch, jump, exception};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: startup cycles left, cycles since the last accepted
  // redirect (0 = pulse cycle, 1..FLUSH_CYCLES = flush window), halted flag.
  int startup_left;
  int since;
  bit halted;
  bit last_accept;
  logic [15:0] m_cnt;
  logic [PC_WIDTH-1:0] m_pc;
  logic [1:0] m_kind;

  function automatic void model_reset();
    startup_left = STARTUP_CYCLES;
    since        = FLUSH_CYCLES + 1;
    halted       = 1'b0;
    m_cnt        = '0;
    m_pc         = '0;
    m_kind       = '0;
  endfunction

  function automatic bit m_window();
    return since <= FLUSH_CYCLES;
  endfunction

  function automatic bit m_ready();
    return (startup_left == 0) && (since != 0);
  endfunction

  function automatic bit m_busy();
    return (startup_left > 0) || m_window() || halted;
  endfunction

  function automatic logic [12:0] m_ctrl();
    bit b = m_busy();
    bit pulse = (since == 0);
    return {!b, !b, b, m_window(), b, b, b || map_full,
            b || rob_full || res_st_full, b, m_ready(),
            pulse && (m_kind == 2'b00), pulse && (m_kind == 2'b01),
            pulse && (m_kind[1] == 1'b1)};
  endfunction

  function automatic void model_step();
    bit acc = redir.redirect_valid && m_ready();
    last_accept = acc;
    if (startup_left > 0) begin
      startup_left--;
      if (startup_left == 0) halted = halt_req;
    end else if (acc) begin
      since  = 0;
      halted = 1'b0;
      m_kind = redir.redirect_kind;
      m_pc   = redir.redirect_pc;
      m_cnt  = m_cnt + 16'd1;
    end else if (m_window()) begin
      since++;
      if (since > FLUSH_CYCLES) halted = halt_req;
    end else begin
      halted = halt_req;
    end
  endfunction

  // Compare on the falling edge, advance the model on the rising edge,
  // hand control back 1 time unit after the edge for new stimulus.
  task automatic tick();
    @(negedge clk);
    check("ctrl", 64'(dut_ctrl), 64'(m_ctrl()));
    check("pc_override", 64'(pc_override), 64'(m_pc));
    check("redirect_cnt", 64'(redirect_cnt), 64'(m_cnt));
    @(posedge clk);
    last_accept = 1'b0;
    if (!rst) model_step();
    #1;
  endtask

  task automatic send_redirect(input logic [1:0] kind, input logic [PC_WIDTH-1:0] pc);
    int waited = 0;
    redir.redirect_valid = 1'b1;
    redir.redirect_kind  = kind;
    redir.redirect_pc    = pc;
    do begin
      tick();
      waited++;
    end while (!last_accept && waited < 40);
    check("accepted", 64'(last_accept), 64'd1);
    redir.redirect_valid = 1'b0;
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (flush === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  int n;
  bit pending;

  initial begin
    redir.redirect_valid = 1'b0;
    redir.redirect_kind  = 2'b00;
    redir.redirect_pc    = '0;
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Startup hold: exactly STARTUP_CYCLES busy cycles, then RUN.
    repeat (STARTUP_CYCLES) tick();
    check("startup_done", 64'({busy, stall, if_en, id_en}), 64'(4'b0011));

    // Single branch redirect.
    send_redirect(2'b00, 32'h0000_0100);
    check("br_pulse", 64'({branch, jump, exception, flush}), 64'(4'b1001));
    check("br_pc", 64'(pc_override), 64'h100);
    count_flush(n);
    check("br_flush_len", 64'(n), 64'd4);
    check("br_run", 64'({if_en, busy}), 64'(2'b10));
    check("br_cnt", 64'(redirect_cnt), 64'd1);

    // Back-to-back: exception lands on the second flush cycle of a jump.
    send_redirect(2'b01, 32'h0000_0200);
    check("jmp_pulse", 64'({branch, jump, exception}), 64'(3'b010));
    tick();
    tick();
    send_redirect(2'b10, 32'h0000_0080);
    check("b2b_pulse", 64'({branch, jump, exception}), 64'(3'b001));
    check("b2b_pc", 64'(pc_override), 64'h80);
    count_flush(n);
    check("b2b_flush_len", 64'(n), 64'd4);
    check("b2b_cnt", 64'(redirect_cnt), 64'd3);

    // Halt, redirect from halt, return to halt, then release.
    halt_req = 1'b1;
    tick();
    check("halt_entry", 64'({if_en, busy}), 64'(2'b01));
    send_redirect(2'b00, 32'h0000_0040);
    check("halt_br", 64'({branch, pc_override}), 64'({1'b1, 32'h40}));
    count_flush(n);
    check("halt_flush_len", 64'(n), 64'd4);
    check("halt_back", 64'({if_en, busy}), 64'(2'b01));
    halt_req = 1'b0;
    tick();
    check("halt_release", 64'({if_en, busy}), 64'(2'b10));

    // Back-pressure only affects the downstream stalls.
    rob_full = 1'b1;
    #1;
    check("bp_rob", 64'({rn_stall, mp_stall, if_en, busy}), 64'(4'b1010));
    map_full = 1'b1;
    #1;
    check("bp_map", 64'({rn_stall, mp_stall, if_en, busy}), 64'(4'b1110));
    repeat (3) tick();
    rob_full = 1'b0;
    map_full = 1'b0;

    // Randomized traffic; the requester holds each request until accepted.
    pending = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!pending && $urandom_range(3) == 0) begin
        pending             = 1'b1;
        redir.redirect_kind = 2'($urandom_range(3));
        redir.redirect_pc   = $urandom;
      end
      redir.redirect_valid = pending;
      if ($urandom_range(15) == 0) halt_req = ~halt_req;
      map_full    = ($urandom_range(3) == 0);
      rob_full    = ($urandom_range(3) == 0);
      res_st_full = ($urandom_range(5) == 0);
      tick();
      if (last_accept) pending = 1'b0;
    end
    redir.redirect_valid = 1'b0;
    halt_req    = 1'b0;
    map_full    = 1'b0;
    rob_full    = 1'b0;
    res_st_full = 1'b0;
    for (int i = 0; i < 30 && busy; i++) tick();
    check("settle_run", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of the pulse cycle.
    send_redirect(2'b01, 32'h0000_1234);
    check("pre_rst_jump", 64'(jump), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_pulses", 64'({branch, jump, exception}), 64'd0);
    check("rst_state", 64'({busy, flush, if_en, redir.redirect_ready}), 64'(4'b1000));
    check("rst_cnt", 64'(redirect_cnt), 64'd0);
    check("rst_pc", 64'(pc_override), 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
    repeat (STARTUP_CYCLES + 1) tick();

    // Asynchronous reset in the middle of the flush window.
    send_redirect(2'b00, 32'h0000_0400);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_flush", 64'({busy, flush, redirect_cnt}), 64'({2'b10, 16'd0}));
    model_reset();
    tick();
    rst = 1'b0;
    repeat (STARTUP_CYCLES + 1) tick();

    // Counter wrap: preload near the top, then two accepts (second reserved kind).
    force dut.redirect_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    release dut.redirect_cnt;
    tick();
    send_redirect(2'b00, 32'h0000_0010);
    count_flush(n);
    send_redirect(2'b11, 32'h0000_0020);
    check("wrap_cnt", 64'(redirect_cnt), 64'd0);
    check("rsvd_exc", 64'({branch, jump, exception}), 64'(3'b001));
    count_flush(n);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
